// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch sequencer placed directly after the program counter
// register. On each fetch it captures the PC value and issues a single-word
// read to instruction memory. It then waits for the memory response and
// latches the returned word into an instruction register for decode. It also
// emits the PC control pulses: inc after a successful fetch, and ld_reserved
// on a fetch fault.
//
// FSM: IDLE -> REQ -> WAIT -> HOLD -> (REQ | IDLE). Every output is registered.
//
// Optional feature (compile-time macro FETCH_TIMEOUT_EN):
//   Defined   : a fetch that sees no mem_ready after TIMEOUT WAIT cycles is
//               abandoned. ld_reserved pulses for one cycle, and the PC then
//               redirects to the trap address.
//   Undefined : WAIT waits indefinitely and ld_reserved is tied low.
//
// Parameters
//   P        MSB index of the address bus (address width P+1)
//   W        instruction word width
//   TIMEOUT  WAIT cycles before a fetch fault (>= 2, timeout build only)
//
// Ports
//   clk          in   rising-edge clock
//   clear        in   synchronous active-high reset
//   run          in   1 = keep fetching, 0 = stop after the current fetch
//   pc_in        in   current PC value, sampled only in REQ
//   mem_addr     out  read address, held from one REQ to the next
//   mem_rd       out  single-cycle read strobe per fetch
//   mem_data     in   read data, valid with mem_ready
//   mem_ready    in   memory response strobe, only honoured in WAIT
//   ir_out       out  latched instruction word
//   ir_valid     out  ir_out holds an unconsumed instruction
//   ir_ack       in   decode consumed ir_out
//   pc_inc       out  one-cycle pulse to PC inc
//   ld_reserved  out  one-cycle pulse to PC ld_reserved (fetch fault)
//   busy         out  1 in any state other than IDLE
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int P       = 15,
    parameter int W       = 16,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         run,
    input  logic [P:0]   pc_in,
    output logic [P:0]   mem_addr,
    output logic         mem_rd,
    input  logic [W-1:0] mem_data,
    input  logic         mem_ready,
    output logic [W-1:0] ir_out,
    output logic         ir_valid,
    input  logic         ir_ack,
    output logic         pc_inc,
    output logic         ld_reserved,
    output logic         busy
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [P:0]         mem_addr_reg, mem_addr_next;
    logic               mem_rd_reg, mem_rd_next;
    logic [W-1:0]       ir_out_reg, ir_out_next;
    logic               ir_valid_reg, ir_valid_next;
    logic               pc_inc_reg, pc_inc_next;
    logic               busy_reg, busy_next;
    // Counts cycles spent in WAIT. It restarts at 0 on every WAIT entry and
    // only triggers a fault when the timeout feature is built in.
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

`ifdef FETCH_TIMEOUT_EN
    logic               ld_reserved_reg, ld_reserved_next;
`endif

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg       <= S_IDLE;
            mem_addr_reg    <= '0;
            mem_rd_reg      <= 1'b0;
            ir_out_reg      <= '0;
            ir_valid_reg    <= 1'b0;
            pc_inc_reg      <= 1'b0;
            busy_reg        <= 1'b0;
            cnt_reg         <= '0;
`ifdef FETCH_TIMEOUT_EN
            ld_reserved_reg <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            mem_addr_reg    <= mem_addr_next;
            mem_rd_reg      <= mem_rd_next;
            ir_out_reg      <= ir_out_next;
            ir_valid_reg    <= ir_valid_next;
            pc_inc_reg      <= pc_inc_next;
            busy_reg        <= busy_next;
            cnt_reg         <= cnt_next;
`ifdef FETCH_TIMEOUT_EN
            ld_reserved_reg <= ld_reserved_next;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        mem_addr_next    = mem_addr_reg;
        mem_rd_next      = 1'b0;
        ir_out_next      = ir_out_reg;
        ir_valid_next    = ir_valid_reg;
        pc_inc_next      = 1'b0;
        cnt_next         = cnt_reg;
`ifdef FETCH_TIMEOUT_EN
        ld_reserved_next = 1'b0;
`endif

        unique case (state_reg)
            S_IDLE: begin
                if (run) begin
                    state_next = S_REQ;
                end
            end

            S_REQ: begin
`ifdef FETCH_TIMEOUT_EN
                // The PC register loads the trap address on the same edge
                // that ends this pulse. Sampling pc_in now would capture the
                // stale address, so wait one cycle for it to land.
                if (!ld_reserved_reg) begin
                    mem_addr_next = pc_in;
                    mem_rd_next   = 1'b1;
                    cnt_next      = '0;
                    state_next    = S_WAIT;
                end
`else
                mem_addr_next = pc_in;
                mem_rd_next   = 1'b1;
                cnt_next      = '0;
                state_next    = S_WAIT;
`endif
            end

            S_WAIT: begin
                // A response on the final WAIT cycle still counts as success.
                if (mem_ready) begin
                    ir_out_next   = mem_data;
                    ir_valid_next = 1'b1;
                    pc_inc_next   = 1'b1;
                    state_next    = S_HOLD;
`ifdef FETCH_TIMEOUT_EN
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    ld_reserved_next = 1'b1;
                    state_next       = run ? S_REQ : S_IDLE;
`endif
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            S_HOLD: begin
                if (ir_ack) begin
                    ir_valid_next = 1'b0;
                    state_next    = run ? S_REQ : S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end

    assign mem_addr = mem_addr_reg;
    assign mem_rd   = mem_rd_reg;
    assign ir_out   = ir_out_reg;
    assign ir_valid = ir_valid_reg;
    assign pc_inc   = pc_inc_reg;
    assign busy     = busy_reg;

`ifdef FETCH_TIMEOUT_EN
    assign ld_reserved = ld_reserved_reg;
`else
    assign ld_reserved = 1'b0;
`endif

endmodule
